// File: rtl/fetch_if.sv
// Fetch stage bus bundle: ROM port, decode handshake, redirect/halt control and status.
// Optional FETCH_MISALIGN_TRAP_EN adds the misaligned-redirect trap signals.
interface fetch_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] rom_addr;
  logic [WIDTH-1:0] rom_instr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_instr;
  logic [WIDTH-1:0] out_pc;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_pc;
  logic             halt_req;
  logic             halted;
  logic [31:0]      fetch_cnt;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic             trap_valid;
  logic [WIDTH-1:0] trap_pc;

  modport master (
    output rom_addr,
    input  rom_instr,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    input  redirect_valid,
    input  redirect_pc,
    input  halt_req,
    output halted,
    output fetch_cnt,
    output trap_valid,
    output trap_pc
  );

  modport slave (
    input  rom_addr,
    output rom_instr,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    output redirect_valid,
    output redirect_pc,
    output halt_req,
    input  halted,
    input  fetch_cnt,
    input  trap_valid,
    input  trap_pc
  );
`else
  modport master (
    output rom_addr,
    input  rom_instr,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    input  redirect_valid,
    input  redirect_pc,
    input  halt_req,
    output halted,
    output fetch_cnt
  );

  modport slave (
    input  rom_addr,
    output rom_instr,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    output redirect_valid,
    output redirect_pc,
    output halt_req,
    input  halted,
    input  fetch_cnt
  );
`endif
endinterface

// File: rtl/fetch_unit.sv
// RV32 instruction-fetch stage: PC, one-entry fetch register, redirect/halt FSM.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirects instead of clearing bits [1:0].
//
// state | meaning
// BOOT  | first cycle after reset, ROM settles, no fetch
// RUN   | fetching, one instruction per cycle when decode keeps up
// HALT  | fetch stopped, held instruction may still drain
module fetch_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [WIDTH-1:0] NOP      = 32'h0000_0013
) (
  input  logic     clk,
  input  logic     rst_n,
  fetch_if.master  bus
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);

  state_e           state_q, state_d;
  logic             halted_q, halted_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_instr_q, out_instr_d;
  logic [WIDTH-1:0] out_pc_q, out_pc_d;
  logic [31:0]      fetch_cnt_q, fetch_cnt_d;

  logic transfer;
  logic trap_req;
  logic redir_take;
  logic load_en;

  assign transfer = out_valid_q & bus.out_ready;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic             trap_valid_q, trap_valid_d;
  logic [WIDTH-1:0] trap_pc_q, trap_pc_d;

  assign trap_req = bus.redirect_valid & (|bus.redirect_pc[1:0]);
`else
  assign trap_req = 1'b0;
`endif

  assign redir_take = bus.redirect_valid & ~trap_req;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= BOOT;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  // FSM: next state; a trap beats a redirect, a redirect beats halt_req
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (bus.halt_req) state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase
    if (redir_take) state_d = RUN;
    if (trap_req)   state_d = HALT;
  end

  // FSM: outputs
  always_comb begin
    load_en  = 1'b0;
    halted_d = (state_d == HALT);
    case (state_q)
      RUN:     load_en = ~bus.redirect_valid & (~out_valid_q | transfer);
      default: load_en = 1'b0;
    endcase
  end

  always_comb begin
    pc_d        = pc_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    fetch_cnt_d = fetch_cnt_q + {31'd0, transfer};
    if (bus.redirect_valid) begin
      out_valid_d = 1'b0;
      out_instr_d = NOP;
      if (redir_take) pc_d = bus.redirect_pc & ALIGN_MASK;
    end else if (load_en) begin
      out_valid_d = 1'b1;
      out_instr_d = bus.rom_instr;
      out_pc_d    = pc_q;
      pc_d        = pc_q + WIDTH'(4);
    end else if (transfer) begin
      out_valid_d = 1'b0;
      out_instr_d = NOP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      out_valid_q <= 1'b0;
      out_instr_q <= NOP;
      out_pc_q    <= '0;
      fetch_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_comb begin
    trap_valid_d = trap_req;
    trap_pc_d    = trap_req ? bus.redirect_pc : trap_pc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_valid_q <= 1'b0;
      trap_pc_q    <= '0;
    end else begin
      trap_valid_q <= trap_valid_d;
      trap_pc_q    <= trap_pc_d;
    end
  end

  assign bus.trap_valid = trap_valid_q;
  assign bus.trap_pc    = trap_pc_q;
`endif

  assign bus.rom_addr  = pc_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_pc    = out_pc_q;
  assign bus.halted    = halted_q;
  assign bus.fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scoreboard bench for fetch_unit; ROM model returns word n at byte address 4n.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_if #(.WIDTH(32)) bus0 ();
  fetch_if #(.WIDTH(32)) bus1 ();

  fetch_unit #(.WIDTH(32), .RESET_PC(32'h0000_0000), .NOP(NOP)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  fetch_unit #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFC), .NOP(NOP)) u_wrap (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  assign bus0.rom_instr = bus0.rom_addr >> 2;
  assign bus1.rom_instr = bus1.rom_addr >> 2;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_cnt = 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Scores a transfer happening this cycle, then advances one clock.
  task automatic tick();
    logic [31:0] e;
    if (bus0.out_valid === 1'b1 && bus0.out_ready === 1'b1) begin
      check("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_pc", bus0.out_pc, e);
        check("sb_instr", bus0.out_instr, e >> 2);
        exp_cnt++;
      end
    end
    @(posedge clk);
    #1;
    check("fetch_cnt", bus0.fetch_cnt, exp_cnt);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_valid"}, {31'd0, bus0.out_valid}, 32'd0);
    check({tag, "_instr"}, bus0.out_instr, NOP);
    check({tag, "_pc"}, bus0.out_pc, 32'd0);
    check({tag, "_rom_addr"}, bus0.rom_addr, 32'd0);
    check({tag, "_halted"}, {31'd0, bus0.halted}, 32'd0);
    check({tag, "_cnt"}, bus0.fetch_cnt, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
    check({tag, "_trap_valid"}, {31'd0, bus0.trap_valid}, 32'd0);
    check({tag, "_trap_pc"}, bus0.trap_pc, 32'd0);
`endif
  endtask

  initial begin
    bus0.out_ready      = 1'b1;
    bus0.redirect_valid = 1'b0;
    bus0.redirect_pc    = 32'd0;
    bus0.halt_req       = 1'b0;
    bus1.out_ready      = 1'b1;
    bus1.redirect_valid = 1'b0;
    bus1.redirect_pc    = 32'd0;
    bus1.halt_req       = 1'b0;

    #12;
    check_reset("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // BOOT cycle, then sequential fetch
    check("boot_valid", {31'd0, bus0.out_valid}, 32'd0);
    check("wrap_rom_addr", bus1.rom_addr, 32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);
    tick();
    check("run_first_valid", {31'd0, bus0.out_valid}, 32'd0);
    check("run_halted", {31'd0, bus0.halted}, 32'd0);
    tick();
    check("first_valid", {31'd0, bus0.out_valid}, 32'd1);
    check("wrap_pc_top", bus1.out_pc, 32'hFFFF_FFFC);
    check("wrap_instr_top", bus1.out_instr, 32'h3FFF_FFFF);
    tick();
    check("wrap_pc_zero", bus1.out_pc, 32'h0);
    check("wrap_instr_zero", bus1.out_instr, 32'h0);
    tick();

    // stall at out_pc=8
    bus0.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", {31'd0, bus0.out_valid}, 32'd1);
      check("stall_pc", bus0.out_pc, 32'h8);
      check("stall_instr", bus0.out_instr, 32'h2);
      check("stall_rom_addr", bus0.rom_addr, 32'hC);
      tick();
    end
    bus0.out_ready = 1'b1;
    tick();
    tick();

    // redirect while a valid instruction transfers
    exp_q.push_back(32'h10);
    bus0.redirect_valid = 1'b1;
    bus0.redirect_pc    = 32'h40;
    tick();
    bus0.redirect_valid = 1'b0;
    check("redir_flush_valid", {31'd0, bus0.out_valid}, 32'd0);
    check("redir_flush_instr", bus0.out_instr, NOP);
    check("redir_rom_addr", bus0.rom_addr, 32'h40);
    exp_q.push_back(32'h40);
    exp_q.push_back(32'h44);
    tick();
    check("redir_valid", {31'd0, bus0.out_valid}, 32'd1);
    check("redir_pc", bus0.out_pc, 32'h40);
    tick();

    // halt, drain, then restart by redirect
    bus0.halt_req = 1'b1;
    tick();
    bus0.halt_req = 1'b0;
    check("halt_halted", {31'd0, bus0.halted}, 32'd1);
    check("halt_last_pc", bus0.out_pc, 32'h48);
    check("halt_rom_addr", bus0.rom_addr, 32'h4C);
    exp_q.push_back(32'h48);
    tick();
    check("halt_drained", {31'd0, bus0.out_valid}, 32'd0);
    tick();
    check("halt_no_load", {31'd0, bus0.out_valid}, 32'd0);
    check("halt_pc_hold", bus0.rom_addr, 32'h4C);
    check("halt_still", {31'd0, bus0.halted}, 32'd1);
    bus0.redirect_valid = 1'b1;
    bus0.redirect_pc    = 32'h100;
    tick();
    bus0.redirect_valid = 1'b0;
    check("resume_halted", {31'd0, bus0.halted}, 32'd0);
    check("resume_valid", {31'd0, bus0.out_valid}, 32'd0);
    check("resume_rom_addr", bus0.rom_addr, 32'h100);
    exp_q.push_back(32'h100);
    tick();
    check("resume_out_valid", {31'd0, bus0.out_valid}, 32'd1);
    check("resume_out_pc", bus0.out_pc, 32'h100);

`ifndef FETCH_MISALIGN_TRAP_EN
    // low bits of the redirect target are dropped
    bus0.redirect_valid = 1'b1;
    bus0.redirect_pc    = 32'h203;
    tick();
    bus0.redirect_valid = 1'b0;
    check("align_rom_addr", bus0.rom_addr, 32'h200);
    check("align_flush", {31'd0, bus0.out_valid}, 32'd0);
    tick();
    check("align_out_pc", bus0.out_pc, 32'h200);
`else
    tick();
`endif

    // async reset during a stall
    bus0.out_ready = 1'b0;
    tick();
    check("pre_rst_valid", {31'd0, bus0.out_valid}, 32'd1);
    check("sb_drained", exp_q.size(), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("async_rst");
    exp_cnt = 32'd0;
    #3;
    rst_n = 1'b1;

`ifdef FETCH_MISALIGN_TRAP_EN
    tick();
    tick();
    check("trap_pre_valid", {31'd0, bus0.trap_valid}, 32'd0);
    bus0.redirect_valid = 1'b1;
    bus0.redirect_pc    = 32'h42;
    tick();
    bus0.redirect_valid = 1'b0;
    check("trap_valid", {31'd0, bus0.trap_valid}, 32'd1);
    check("trap_pc", bus0.trap_pc, 32'h42);
    check("trap_halted", {31'd0, bus0.halted}, 32'd1);
    check("trap_flush", {31'd0, bus0.out_valid}, 32'd0);
    check("trap_pc_hold", bus0.rom_addr, 32'h4);
    tick();
    check("trap_pulse_end", {31'd0, bus0.trap_valid}, 32'd0);
    check("trap_pc_held", bus0.trap_pc, 32'h42);
    check("trap_halted_held", {31'd0, bus0.halted}, 32'd1);
`else
    tick();
    check("post_rst_boot_valid", {31'd0, bus0.out_valid}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
